// File: rtl/round_column_accumulate.sv
// Column-serial AES round accumulator: XORs four rotated T-table words per beat
// into the output columns plus round key; emits a 128-bit state every 4 beats.
// Ports: clk, rst_n, in_valid/in_ready, p0..p3, key_in, out_valid/out_ready, out_state.
// Optional: define RCA_ABORT_EN to add the 'abort' input (clears a block in flight).
module round_column_accumulate #(
  parameter bit KEY_XOR = 1'b1,
  parameter int COL_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef RCA_ABORT_EN
  input  logic               abort,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COL_W-1:0]   p0,
  input  logic [COL_W-1:0]   p1,
  input  logic [COL_W-1:0]   p2,
  input  logic [COL_W-1:0]   p3,
  input  logic [4*COL_W-1:0] key_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*COL_W-1:0] out_state
);

  if (COL_W != 32) begin : g_col_w_check
    $error("round_column_accumulate: COL_W must be 32");
  end

  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                  state;
  logic [1:0]              cnt;
  logic [3:0][COL_W-1:0]   acc;
  logic [3:0][COL_W-1:0]   nxt;
  logic [3:0][COL_W-1:0]   pw;
  logic [3:0][COL_W-1:0]   kw;
  logic                    kill;

`ifdef RCA_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // pw[k] is lookup word k; kw[c] is round key column c (k0 in the MSBs).
  assign pw = {p3, p2, p1, p0};
  assign kw = {key_in[COL_W-1:0],
               key_in[2*COL_W-1:COL_W],
               key_in[3*COL_W-1:2*COL_W],
               key_in[4*COL_W-1:3*COL_W]};

  // In FULL the pending beat is always beat 0 of the next block, and cnt
  // is parked at 0 there, so the same next-value logic serves both states.
  assign in_ready = (state == ACCUM) || out_ready;

  // Column c receives word k where c = cnt - k (mod 4), i.e. k = cnt - c.
  // Beat 0 seeds every column with its key (or zero) instead of old acc.
  always_comb begin
    nxt = acc;
    for (int c = 0; c < 4; c++) begin
      nxt[c] = ((cnt == 2'd0) ? (KEY_XOR ? kw[c] : '0) : acc[c])
             ^ pw[2'(cnt - 2'(c))];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      cnt       <= 2'd0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_state <= '0;
    end else if (kill) begin
      state     <= ACCUM;
      cnt       <= 2'd0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= nxt;
            if (cnt == 2'd3) begin
              state     <= FULL;
              cnt       <= 2'd0;
              out_valid <= 1'b1;
              out_state <= {nxt[0], nxt[1], nxt[2], nxt[3]};
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            if (in_valid) begin
              acc <= nxt;
              cnt <= 2'd1;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_round_column_accumulate.sv
// Self-checking bench for round_column_accumulate: directed + random blocks
// checked against a column-identity reference model.
module tb_round_column_accumulate;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [31:0]  p0 = '0, p1 = '0, p2 = '0, p3 = '0;
  logic [127:0] key_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_state;
`ifdef RCA_ABORT_EN
  logic         abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0]  bw [4][4];
  logic [127:0] bkey;
  logic [127:0] hold;

  always #5 clk = ~clk;

  round_column_accumulate dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef RCA_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p0        (p0),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  // Out column c = k_c ^ p0(beat c) ^ p1(beat c+1) ^ p2(beat c+2) ^ p3(beat c+3).
  function automatic logic [127:0] model();
    logic [127:0] r;
    logic [31:0]  v;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      v = bkey[127-32*c -: 32];
      for (int w = 0; w < 4; w++) v = v ^ bw[(c + w) % 4][w];
      r[127-32*c -: 32] = v;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_block();
    bkey = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 4; w++) bw[b][w] = $urandom;
  endtask

  task automatic zero_block();
    bkey = '0;
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 4; w++) bw[b][w] = '0;
  endtask

  // Key is only meaningful on beat 0; later beats carry junk on purpose.
  task automatic drive(input int b);
    in_valid = 1'b1;
    p0 = bw[b][0];
    p1 = bw[b][1];
    p2 = bw[b][2];
    p3 = bw[b][3];
    key_in = (b == 0) ? bkey : {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle();
    in_valid = 1'b0;
    p0 = $urandom;
    p1 = $urandom;
    p2 = $urandom;
    p3 = $urandom;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic send(input int from, input int to, input bit gaps);
    for (int b = from; b <= to; b++) begin
      if (gaps && b != from && $urandom_range(0, 1) == 1) begin
        idle();
        step();
      end
      drive(b);
      step();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    idle();
    step();
    step();
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_state", out_state, 128'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // Zero-word key pass-through
    zero_block();
    bkey = 128'h000102030405060708090A0B0C0D0E0F;
    send(0, 3, 1'b0);
    chk("pass_valid", {127'd0, out_valid}, 128'd1);
    chk("pass_state", out_state, 128'h000102030405060708090A0B0C0D0E0F);
    step();
    chk("pass_drain", {127'd0, out_valid}, 128'd0);

    // Column routing
    zero_block();
    bw[0][1] = 32'hAABBCCDD;
    bw[2][3] = 32'h11223344;
    send(0, 3, 1'b0);
    chk("route_state", out_state, 128'h00000000_00000000_00000000_BB99FF99);
    step();

    // Random blocks with gaps between beats
    for (int n = 0; n < 4; n++) begin
      rand_block();
      send(0, 3, 1'b1);
      chk("gap_valid", {127'd0, out_valid}, 128'd1);
      chk("gap_state", out_state, model());
      step();
      chk("gap_drain", {127'd0, out_valid}, 128'd0);
    end

    // Backpressure
    rand_block();
    send(0, 3, 1'b0);
    hold = model();
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      p0 = $urandom;
      p1 = $urandom;
      p2 = $urandom;
      p3 = $urandom;
      #1;
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      step();
      chk("bp_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_state", out_state, hold);
    end
    rand_block();
    out_ready = 1'b1;
    drive(0);
    #1;
    chk("bp_release_ready", {127'd0, in_ready}, 128'd1);
    step();
    chk("bp_taken", {127'd0, out_valid}, 128'd0);
    send(1, 3, 1'b0);
    chk("bp_next_valid", {127'd0, out_valid}, 128'd1);
    chk("bp_next_state", out_state, model());
    step();

    // Back-to-back stream, no bubbles
    for (int blk = 0; blk < 3; blk++) begin
      rand_block();
      for (int b = 0; b < 4; b++) begin
        drive(b);
        step();
      end
      chk("b2b_valid", {127'd0, out_valid}, 128'd1);
      chk("b2b_state", out_state, model());
    end
    idle();
    step();
    chk("b2b_drain", {127'd0, out_valid}, 128'd0);

    // Reset mid-block
    rand_block();
    send(0, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_state", out_state, 128'd0);
    step();
    rst_n = 1'b1;
    step();
    rand_block();
    send(0, 3, 1'b0);
    chk("post_rst_valid", {127'd0, out_valid}, 128'd1);
    chk("post_rst_state", out_state, model());
    step();

`ifdef RCA_ABORT_EN
    // Abort after beat 1, simultaneous beat dropped
    rand_block();
    send(0, 1, 1'b0);
    abort = 1'b1;
    drive(2);
    step();
    abort = 1'b0;
    idle();
    for (int n = 0; n < 4; n++) begin
      chk("abort_no_out", {127'd0, out_valid}, 128'd0);
      step();
    end
    rand_block();
    send(0, 3, 1'b0);
    chk("abort_next_valid", {127'd0, out_valid}, 128'd1);
    chk("abort_next_state", out_state, model());

    // Abort together with an output handshake
    rand_block();
    out_ready = 1'b1;
    drive(0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    idle();
    chk("abort_hs_valid", {127'd0, out_valid}, 128'd0);
    send(0, 3, 1'b0);
    chk("abort_hs_next", out_state, model());
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_column_accumulate.md
Name: round_column_accumulate

Overview:
- Downstream consumer of the column T-table lookup stage in the AES round datapath.
- Takes the four rotated T-table words produced for one input column per beat and XOR-accumulates them into the correct output columns, together with the round key.
- After four beats it presents a complete 128-bit next-round state through a valid/ready handshake.
- Lets one shared lookup stage serve a column-serial round, which costs far less area than four parallel lookup stages.

Parameters:
KEY_XOR, 1, 1 = XOR round key into result; 0 = omit key (debug/characterisation).
COL_W, 32, column width; fixed at 32, any other value is a configuration error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  p0..p3 (and key_in on beat 0) valid this cycle
in_ready  output  1  block can accept a beat this cycle
p0  input  32  lookup word for byte 0 of input column i
p1  input  32  lookup word for byte 1 of input column i
p2  input  32  lookup word for byte 2 of input column i
p3  input  32  lookup word for byte 3 of input column i
key_in  input  128  round key {k0,k1,k2,k3}, k0 at [127:96]; sampled only on beat 0
out_valid  output  1  out_state holds a complete round result
out_ready  input  1  downstream accepts out_state
out_state  output  128  next state {c0,c1,c2,c3}, c0 at [127:96]

Behaviour:
- Beat counter: cnt[1:0] gives the input column index i. Beats arrive in order i = 0,1,2,3; there is no column-index input.
- Accumulator: acc[0..3], 32 bits each. A beat fires when in_valid && in_ready. On a beat with column i:
  - acc[i] ^= p0
  - acc[(i-1) mod 4] ^= p1
  - acc[(i-2) mod 4] ^= p2
  - acc[(i-3) mod 4] ^= p3
- Beat 0 does not XOR into old contents. It loads acc[c] = (KEY_XOR ? k_c : 0) ^ contribution_c, where contribution_c is zero for columns that receive no word on this beat.
- Result identity: out column c = k_c ^ p0(col c) ^ p1(col c+1) ^ p2(col c+2) ^ p3(col c+3), indices mod 4.
- FSM:
  - ACCUM: cnt = 0..3. in_ready = 1. A beat with cnt = 3 moves to FULL and copies the final acc value into the out_state register.
  - FULL: out_valid = 1; out_state is held stable.
    - in_ready = out_ready (pass-through).
    - out_ready && !in_valid -> ACCUM, cnt = 0.
    - out_ready && in_valid -> the result is taken and beat 0 of the next block is accepted in the same cycle; next state ACCUM, cnt = 1. No bubble.
    - !out_ready -> stay in FULL; in_ready = 0; input is ignored.
- Latency: out_valid rises on the cycle after the 4th beat. Throughput is one 128-bit result per 4 cycles.
- in_valid low mid-block: the counter holds and acc holds; gaps between beats are allowed.
- Output is registered. out_state does not change while out_valid && !out_ready.
- Reset (asynchronous assert, synchronous deassert by the reset tree):
  - state = ACCUM, cnt = 0, acc = 0
  - out_state = 0, out_valid = 0
  - in_ready = 1 from the first cycle after deassertion
- Reset mid-block discards the partial accumulation. No partial result is ever emitted.
- key_in is ignored on beats 1..3.

Optional Feature:
Macro: RCA_ABORT_EN
- With the macro defined: add input port abort (1 bit).
  - abort high at a clock edge forces ACCUM, cnt = 0, out_valid = 0 and discards acc. A simultaneous beat is dropped.
  - abort has priority over every other event, including an out_ready handshake in the same cycle.
- Without the macro: no abort port. A block can only be cleared by rst_n.

Test Plan:
- Zero-word key pass-through: four beats with p0..p3 = 0 and key_in = 0x000102030405060708090A0B0C0D0E0F -> one cycle after beat 3, out_valid = 1 and out_state = 0x000102030405060708090A0B0C0D0E0F.
- Column routing: key 0; beat 0 p1 = 0xAABBCCDD, beat 2 p3 = 0x11223344, all other words 0 -> out_state = 0x00000000_00000000_00000000_AABBCCDD ^ (0x11223344 in column 3), i.e. [31:0] = 0xBB99FF99 and all other columns 0.
- Backpressure: hold out_ready = 0 for 5 cycles after the result -> out_state stable, in_ready = 0, in_valid beats not absorbed. Then out_ready = 1 with in_valid = 1 -> result accepted and next beat 0 absorbed in the same cycle (cnt = 1).
- Back-to-back stream: 3 blocks with in_valid held high and out_ready held high -> results every 4 cycles, each equal to a software T-table reference model, no lost beats.
- Reset mid-block: pull rst_n low after beat 2 -> out_valid = 0 and out_state = 0 immediately. A fresh 4-beat block after release gives the correct result, uncorrupted by stale acc.
- RCA_ABORT_EN build: abort after beat 1 -> no output. The next 4-beat block gives the exact expected value. abort in the same cycle as an out_ready handshake -> out_valid = 0 next cycle.
